// File: rtl/servo_pkg.sv
// Shared mode encoding, position width and default limits for the servo PWM block.
// SERVO_SLEW_EN (see servo_chan) selects slewed HOLD moves.
package servo_pkg;

    localparam int PW_W          = 20;
    localparam int PERIOD_DEF    = 500000;
    localparam int PULSE_MIN_DEF = 16000;
    localparam int PULSE_MAX_DEF = 66000;
    localparam int STEP_DIV_DEF  = 2500;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_HOLD    = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    function automatic logic [PW_W-1:0] clamp_pw(
        input logic [PW_W-1:0] w,
        input logic [PW_W-1:0] lo,
        input logic [PW_W-1:0] hi
    );
        if (w < lo) return lo;
        if (w > hi) return hi;
        return w;
    endfunction

endpackage

// File: rtl/servo_chan.sv
// Per-channel mode and position state machine for servo_sweep_pwm.
// Define SERVO_SLEW_EN to make HOLD slew one count per step instead of jumping.
module servo_chan
    import servo_pkg::*;
#(
    parameter int PULSE_MIN = PULSE_MIN_DEF,
    parameter int PULSE_MAX = PULSE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step_tick,
    input  logic            cmd_load,
    input  mode_e           cmd_mode,
    input  logic [PW_W-1:0] cmd_width,
    output logic [PW_W-1:0] pos,
    output logic            done,
    output logic            is_off
);

    localparam logic [PW_W-1:0] PMIN = PW_W'(PULSE_MIN);
    localparam logic [PW_W-1:0] PMAX = PW_W'(PULSE_MAX);

    mode_e           mode;
    logic            dir_up;
    logic [PW_W-1:0] width_c;
`ifdef SERVO_SLEW_EN
    logic [PW_W-1:0] target;
`endif

    assign width_c = clamp_pw(cmd_width, PMIN, PMAX);
    assign is_off  = (mode == MODE_OFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= MODE_OFF;
            dir_up <= 1'b0;
            pos    <= PMAX;
            done   <= 1'b0;
`ifdef SERVO_SLEW_EN
            target <= PMAX;
`endif
        end else if (cmd_load) begin
            // a new command always starts from the current position
            mode <= cmd_mode;
            done <= 1'b0;
            case (cmd_mode)
                MODE_BOUNCE:  dir_up <= 1'b0;
                MODE_ONESHOT: dir_up <= (pos - PMIN) < (PMAX - pos);
                default:      dir_up <= dir_up;
            endcase
`ifdef SERVO_SLEW_EN
            if (cmd_mode == MODE_HOLD) target <= width_c;
`else
            if (cmd_mode == MODE_HOLD) pos <= width_c;
`endif
        end else if (step_tick) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (dir_up) begin
                        if (pos >= PMAX) begin
                            dir_up <= 1'b0;
                            pos    <= pos - 1'b1;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end else begin
                        if (pos <= PMIN) begin
                            dir_up <= 1'b1;
                            pos    <= pos + 1'b1;
                        end else begin
                            pos <= pos - 1'b1;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (!done) begin
                        if (dir_up) begin
                            if (pos < PMAX) pos <= pos + 1'b1;
                            if (pos >= PMAX - 1'b1) done <= 1'b1;
                        end else begin
                            if (pos > PMIN) pos <= pos - 1'b1;
                            if (pos <= PMIN + 1'b1) done <= 1'b1;
                        end
                    end
                end
`ifdef SERVO_SLEW_EN
                MODE_HOLD: begin
                    if (pos < target)      pos <= pos + 1'b1;
                    else if (pos > target) pos <= pos - 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/servo_sweep_pwm.sv
// Multi-channel servo PWM with frame timebase, step prescaler and command handshake.
// SERVO_SLEW_EN is honoured inside servo_chan.
module servo_sweep_pwm
    import servo_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int PERIOD    = PERIOD_DEF,
    parameter int PULSE_MIN = PULSE_MIN_DEF,
    parameter int PULSE_MAX = PULSE_MAX_DEF,
    parameter int STEP_DIV  = STEP_DIV_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_ch,
    input  logic [1:0]             cmd_mode,
    input  logic [PW_W-1:0]        cmd_width,
    output logic [NUM_CH-1:0]      servo,
    output logic [NUM_CH*PW_W-1:0] pos,
    output logic [NUM_CH-1:0]      done,
    output logic                   frame_start
);

    localparam logic [PW_W-1:0] CNT_LAST = PW_W'(PERIOD - 1);
    localparam logic [PW_W-1:0] PRE_LAST = PW_W'(STEP_DIV - 1);

    logic [PW_W-1:0]   cnt;
    logic [PW_W-1:0]   pre;
    logic              frame_wrap;
    logic              step_tick;
    logic              cmd_acc;
    logic [NUM_CH-1:0] is_off;

    assign frame_wrap = (cnt == CNT_LAST);
    assign step_tick  = (pre == PRE_LAST);
    // blocking commands on the wrap cycle keeps shadow loads race-free
    assign cmd_ready  = !frame_wrap;
    assign cmd_acc    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            pre         <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= frame_wrap ? '0 : cnt + 1'b1;
            pre         <= step_tick ? '0 : pre + 1'b1;
            frame_start <= frame_wrap;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PW_W-1:0] ch_pos;
        logic [PW_W-1:0] shadow;

        servo_chan #(
            .PULSE_MIN (PULSE_MIN),
            .PULSE_MAX (PULSE_MAX)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .step_tick (step_tick),
            .cmd_load  (cmd_acc && (cmd_ch == 3'(gi))),
            .cmd_mode  (mode_e'(cmd_mode)),
            .cmd_width (cmd_width),
            .pos       (ch_pos),
            .done      (done[gi]),
            .is_off    (is_off[gi])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst)             shadow <= '0;
            else if (frame_wrap) shadow <= is_off[gi] ? '0 : ch_pos;
        end

        assign pos[gi*PW_W +: PW_W] = ch_pos;
        assign servo[gi]            = (cnt < shadow);
    end

endmodule

// File: tb/tb_servo_sweep_pwm.sv
// Scoreboard bench for servo_sweep_pwm: per-frame pulse widths, positions and
// done flags against a tick-level behavioural model (honours SERVO_SLEW_EN).
module tb_servo_sweep_pwm;

    localparam int NUM_CH   = 2;
    localparam int PERIOD   = 100;
    localparam int PMIN     = 10;
    localparam int PMAX     = 60;
    localparam int STEP_DIV = 4;

    localparam int M_OFF     = 0;
    localparam int M_HOLD    = 1;
    localparam int M_BOUNCE  = 2;
    localparam int M_ONESHOT = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [2:0]             cmd_ch = '0;
    logic [1:0]             cmd_mode = '0;
    logic [19:0]            cmd_width = '0;
    logic [NUM_CH-1:0]      servo;
    logic [NUM_CH*20-1:0]   pos;
    logic [NUM_CH-1:0]      done;
    logic                   frame_start;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [NUM_CH-1:0][19:0] sh;
        logic [NUM_CH-1:0][19:0] p;
        logic [NUM_CH-1:0]       d;
    } exp_t;

    exp_t exp_q[$];

    int m_t;
    int m_pos[NUM_CH];
    int m_goal[NUM_CH];
    int m_mode[NUM_CH];
    int m_sh[NUM_CH];
    bit m_done[NUM_CH];

    servo_sweep_pwm #(
        .NUM_CH    (NUM_CH),
        .PERIOD    (PERIOD),
        .PULSE_MIN (PMIN),
        .PULSE_MAX (PMAX),
        .STEP_DIV  (STEP_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_mode    (cmd_mode),
        .cmd_width   (cmd_width),
        .servo       (servo),
        .pos         (pos),
        .done        (done),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clampw(input int w);
        return (w < PMIN) ? PMIN : ((w > PMAX) ? PMAX : w);
    endfunction

    function automatic int toward(input int p, input int g);
        return (p < g) ? p + 1 : ((p > g) ? p - 1 : p);
    endfunction

    function automatic int dut_pos(input int ch);
        return int'(pos[ch*20 +: 20]);
    endfunction

    task automatic m_reset();
        m_t = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_pos[c]  = PMAX;
            m_goal[c] = PMIN;
            m_mode[c] = M_OFF;
            m_sh[c]   = 0;
            m_done[c] = 1'b0;
        end
    endtask

    task automatic m_step();
        exp_t e;
        bit   wrap;
        bit   tick;
        bit   acc;
        wrap = (m_t % PERIOD) == PERIOD - 1;
        tick = (m_t % STEP_DIV) == STEP_DIV - 1;
        acc  = cmd_valid && !wrap;
        if (wrap)
            for (int c = 0; c < NUM_CH; c++)
                m_sh[c] = (m_mode[c] == M_OFF) ? 0 : m_pos[c];
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc && int'(cmd_ch) == c) begin
                m_mode[c] = int'(cmd_mode);
                m_done[c] = 1'b0;
                case (m_mode[c])
                    M_HOLD:    m_goal[c] = clampw(int'(cmd_width));
                    M_BOUNCE:  m_goal[c] = PMIN;
                    M_ONESHOT: m_goal[c] = (m_pos[c] - PMIN >= PMAX - m_pos[c]) ? PMIN : PMAX;
                    default: ;
                endcase
`ifndef SERVO_SLEW_EN
                if (m_mode[c] == M_HOLD) m_pos[c] = m_goal[c];
`endif
            end else if (tick) begin
                case (m_mode[c])
                    M_BOUNCE: begin
                        if (m_pos[c] == m_goal[c])
                            m_goal[c] = (m_goal[c] == PMIN) ? PMAX : PMIN;
                        m_pos[c] = toward(m_pos[c], m_goal[c]);
                    end
                    M_ONESHOT: begin
                        if (!m_done[c]) begin
                            m_pos[c]  = toward(m_pos[c], m_goal[c]);
                            m_done[c] = (m_pos[c] == m_goal[c]);
                        end
                    end
                    M_HOLD: m_pos[c] = toward(m_pos[c], m_goal[c]);
                    default: ;
                endcase
            end
        end
        m_t++;
        if (wrap) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e.sh[c] = 20'(m_sh[c]);
                e.p[c]  = 20'(m_pos[c]);
                e.d[c]  = m_done[c];
            end
            exp_q.push_back(e);
        end
    endtask

    // reference model advances on every clock edge
    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_reset();
                exp_q.delete();
            end else begin
                m_step();
            end
        end
    end

    // monitor: pops one expectation per frame_start, measures each frame's pulses
    initial begin
        int   hi[NUM_CH];
        int   cur_w[NUM_CH];
        bit   have;
        exp_t e;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 1'b0;
            end else begin
                for (int c = 0; c < NUM_CH; c++)
                    chk($sformatf("range_ch%0d", c),
                        int'(dut_pos(c) >= PMIN && dut_pos(c) <= PMAX), 1);
                if (frame_start) begin
                    if (have)
                        for (int c = 0; c < NUM_CH; c++)
                            chk($sformatf("width_ch%0d", c), hi[c], cur_w[c]);
                    if (exp_q.size() == 0) begin
                        chk("frame_queue_nonempty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        for (int c = 0; c < NUM_CH; c++) begin
                            chk($sformatf("frame_pos_ch%0d", c), dut_pos(c), int'(e.p[c]));
                            chk($sformatf("frame_done_ch%0d", c), int'(done[c]), int'(e.d[c]));
                            cur_w[c] = int'(e.sh[c]);
                        end
                        have = 1'b1;
                    end
                    for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
                end
                for (int c = 0; c < NUM_CH; c++) hi[c] += int'(servo[c]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int mode, input int w);
        bit ok;
        ok        = 1'b0;
        cmd_ch    = 3'(ch);
        cmd_mode  = 2'(mode);
        cmd_width = 20'(w);
        cmd_valid = 1'b1;
        for (int k = 0; k < 4 && !ok; k++) begin
            @(negedge clk);
            chk("cmd_ready", int'(cmd_ready), int'((m_t % PERIOD) != PERIOD - 1));
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int c);
        int k;
        k = 0;
        while ((m_t % PERIOD) != c && k < 2 * PERIOD) begin
            @(posedge clk);
            #1;
            k++;
        end
        if ((m_t % PERIOD) != c) chk("wait_cnt_timeout", m_t % PERIOD, c);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_servo"}, int'(servo), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("%s_pos_ch%0d", tag, c), dut_pos(c), PMAX);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cyc(3);
        chk_reset_state("reset");
        rst = 1'b0;
        cyc(2);

        send(0, M_HOLD, 30);
        cyc(3 * PERIOD);

        wait_cnt(PERIOD - 1);
        send(0, M_HOLD, 40);
        chk("accepted_at_cnt0", m_t % PERIOD, 1);
        chk("pos0_after_wrap_cmd", dut_pos(0), m_pos[0]);
        wait_cnt(10);
        send(0, M_HOLD, 50);
        cyc(2 * PERIOD);

        send(0, M_HOLD, 5);
        chk("hold_low_model", dut_pos(0), m_pos[0]);
`ifndef SERVO_SLEW_EN
        chk("hold_low_clamp", dut_pos(0), PMIN);
`endif
        send(0, M_HOLD, 90);
        chk("hold_high_model", dut_pos(0), m_pos[0]);
`ifndef SERVO_SLEW_EN
        chk("hold_high_clamp", dut_pos(0), PMAX);
`endif
        send(5, M_HOLD, 20);
        chk("bad_ch_pos0", dut_pos(0), m_pos[0]);
        chk("bad_ch_pos1", dut_pos(1), PMAX);

        send(0, M_HOLD, 60);
        cyc(60 * STEP_DIV);
        send(0, M_ONESHOT, 0);
        cyc(49 * STEP_DIV);
        chk("oneshot_49_pos", dut_pos(0), PMIN + 1);
        chk("oneshot_49_done", int'(done[0]), 0);
        cyc(STEP_DIV);
        chk("oneshot_50_pos", dut_pos(0), PMIN);
        chk("oneshot_50_done", int'(done[0]), 1);
        cyc(10 * STEP_DIV);
        chk("oneshot_hold_pos", dut_pos(0), PMIN);
        chk("oneshot_hold_done", int'(done[0]), 1);

        send(1, M_BOUNCE, 0);
        cyc(50 * STEP_DIV);
        chk("bounce_bottom", dut_pos(1), PMIN);
        cyc(25 * STEP_DIV);
        chk("bounce_rising", dut_pos(1), PMIN + 25);

        send(0, M_HOLD, 30);
        cyc(3 * PERIOD);
        wait_cnt(5);
        #2;
        chk("servo0_before_rst", int'(servo[0]), int'(m_sh[0] > 5));
        rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        cyc(2);
        rst = 1'b0;
        cyc(2);

`ifdef SERVO_SLEW_EN
        send(0, M_HOLD, 30);
        cyc(29 * STEP_DIV);
        chk("slew_29", dut_pos(0), 31);
        cyc(STEP_DIV);
        chk("slew_30", dut_pos(0), 30);
        cyc(4 * STEP_DIV);
        chk("slew_settled", dut_pos(0), 30);
`endif

        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(1, 150));
            send($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 80));
        end
        cyc(3 * PERIOD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
